// File: rtl/serial_ripple_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The slave side is the subtractor; the master side is whoever feeds operands and takes results.
interface serial_ripple_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, bout, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, bout, busy
    );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b, LSB first, one full-subtractor
// cell reused over WIDTH cycles with a registered borrow between bit positions.
module serial_ripple_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    serial_ripple_subtractor_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg,  state_next;
    logic [WIDTH-1:0] ra_reg,     ra_next;
    logic [WIDTH-1:0] rb_reg,     rb_next;
    logic [WIDTH-1:0] diff_reg,   diff_next;
    logic             borrow_reg, borrow_next;
    logic             bout_reg,   bout_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;

    logic             d_bit;
    logic             borrow_bit;
    logic [WIDTH-1:0] ra_shift;
    logic [WIDTH-1:0] rb_shift;
    logic [WIDTH-1:0] diff_shift;

    // Single full-subtractor cell working on the current LSB of the operand registers.
    assign d_bit      = ra_reg[0] ^ rb_reg[0] ^ borrow_reg;
    assign borrow_bit = (~ra_reg[0] & rb_reg[0]) | (~(ra_reg[0] ^ rb_reg[0]) & borrow_reg);

    // Operands shift right each step; the new difference bit enters at the MSB of diff,
    // so after WIDTH steps the first bit computed has arrived at diff[0].
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_top
                assign ra_shift[gi]   = 1'b0;
                assign rb_shift[gi]   = 1'b0;
                assign diff_shift[gi] = d_bit;
            end else begin : g_body
                assign ra_shift[gi]   = ra_reg[gi+1];
                assign rb_shift[gi]   = rb_reg[gi+1];
                assign diff_shift[gi] = diff_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        ra_next     = ra_reg;
        rb_next     = rb_reg;
        diff_next   = diff_reg;
        borrow_next = borrow_reg;
        bout_next   = bout_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    ra_next     = bus.a;
                    rb_next     = bus.b;
                    diff_next   = '0;
                    borrow_next = 1'b0;
                    cnt_next    = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                ra_next     = ra_shift;
                rb_next     = rb_shift;
                diff_next   = diff_shift;
                borrow_next = borrow_bit;
                cnt_next    = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_LAST) begin
                    bout_next  = borrow_bit;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            ra_reg     <= '0;
            rb_reg     <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            bout_reg   <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            ra_reg     <= ra_next;
            rb_reg     <= rb_next;
            diff_reg   <= diff_next;
            borrow_reg <= borrow_next;
            bout_reg   <= bout_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.busy      = (state_reg == RUN);
    assign bus.diff      = diff_reg;
    assign bus.bout      = bout_reg;
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Bench for the bit-serial subtractor: directed WIDTH=4 cases with literal expectations,
// then a WIDTH=8 sweep, all results also cross-checked against an arithmetic model.
module tb_serial_ripple_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   sweep_on = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_ripple_subtractor_if #(.WIDTH(4)) if4 ();
    serial_ripple_subtractor_if #(.WIDTH(8)) if8 ();

    serial_ripple_subtractor #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    serial_ripple_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {bout,diff} as one number: borrow weighs 2^w, difference is plain modular arithmetic.
    function automatic int sub_model(input int a, input int b, input int w);
        int m;
        m = 1 << w;
        return ((a < b) ? m : 0) + ((a - b + m) % m);
    endfunction

    // Compare process: tracks accepted operands and checks every cycle a result is visible.
    int q4[$], acc4[$], q8[$], acc8[$];
    bit seen4 = 1'b0, seen8 = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q4.delete(); acc4.delete(); seen4 = 1'b0;
            q8.delete(); acc8.delete(); seen8 = 1'b0;
        end else begin
            if (if4.out_valid) begin
                if (q4.size() == 0) begin
                    check("w4_unexpected_valid", 1, 0);
                end else begin
                    if (!seen4) begin
                        check("w4_latency", cyc - acc4[0], 4);
                        seen4 = 1'b1;
                    end
                    check("w4_model", {if4.bout, if4.diff}, q4[0]);
                    if (if4.out_ready) begin
                        $display("w4 result diff=%0d bout=%0d", if4.diff, if4.bout);
                        void'(q4.pop_front()); void'(acc4.pop_front()); seen4 = 1'b0;
                    end
                end
            end
            if (if4.in_valid && if4.in_ready) begin
                q4.push_back(sub_model(int'(if4.a), int'(if4.b), 4));
                acc4.push_back(cyc + 1);
            end
            if (if8.out_valid) begin
                if (q8.size() == 0) begin
                    check("w8_unexpected_valid", 1, 0);
                end else begin
                    if (!seen8) begin
                        check("w8_latency", cyc - acc8[0], 8);
                        seen8 = 1'b1;
                    end
                    check("w8_model", {if8.bout, if8.diff}, q8[0]);
                    if (if8.out_ready) begin
                        $display("w8 result diff=%0d bout=%0d", if8.diff, if8.bout);
                        void'(q8.pop_front()); void'(acc8.pop_front()); seen8 = 1'b0;
                    end
                end
            end
            if (if8.in_valid && if8.in_ready) begin
                q8.push_back(sub_model(int'(if8.a), int'(if8.b), 8));
                acc8.push_back(cyc + 1);
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (sweep_on) if8.out_ready = 1'($urandom_range(0, 1));
    end

    task automatic wait_valid4(output int busy_cnt);
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (if4.out_valid) return;
            if (if4.busy) busy_cnt++;
            @(posedge clk); #1;
        end
        check("w4_valid_timeout", 0, 1);
    endtask

    // Called #1 after an edge with the WIDTH=4 DUT idle.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input int hold,
                       input int ed, input int eb, input string tag);
        int nb;
        check({tag, "_in_ready"}, if4.in_ready, 1);
        if4.a = a; if4.b = b; if4.in_valid = 1'b1; if4.out_ready = 1'b0;
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
        wait_valid4(nb);
        check({tag, "_busy_cycles"}, nb, 4);
        check({tag, "_diff"}, if4.diff, ed);
        check({tag, "_bout"}, if4.bout, eb);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, if4.out_valid, 1);
            check({tag, "_hold_diff"}, if4.diff, ed);
            check({tag, "_hold_bout"}, if4.bout, eb);
        end
        if4.out_ready = 1'b1;
        @(posedge clk); #1;
        if4.out_ready = 1'b0;
        check({tag, "_valid_drop"}, if4.out_valid, 0);
        check({tag, "_back_idle"}, if4.in_ready, 1);
    endtask

    initial begin
        int nb;
        if4.in_valid = 1'b0; if4.out_ready = 1'b0; if4.a = '0; if4.b = '0;
        if8.in_valid = 1'b0; if8.out_ready = 1'b0; if8.a = '0; if8.b = '0;

        #2;
        check("rst_in_ready", if4.in_ready, 1);
        check("rst_out_valid", if4.out_valid, 0);
        check("rst_busy", if4.busy, 0);
        check("rst_diff", if4.diff, 0);
        check("rst_bout", if4.bout, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Model pinned by hand-computed values.
        check("model_9_3", sub_model(9, 3, 4), 6);
        check("model_3_9", sub_model(3, 9, 4), 26);
        check("model_0_255", sub_model(0, 255, 8), 257);

        op4(4'd9,  4'd3,  0, 6,  0, "t1_9m3");
        op4(4'd3,  4'd9,  0, 10, 1, "t2_3m9");
        op4(4'd0,  4'd0,  0, 0,  0, "t2_0m0");
        op4(4'd15, 4'd15, 0, 0,  0, "t2_15m15");
        op4(4'd0,  4'd15, 0, 1,  1, "t2_0m15");
        op4(4'd15, 4'd0,  0, 15, 0, "t2_15m0");
        op4(4'd12, 4'd5,  7, 7,  0, "t3_backpressure");

        // Operands changed and in_valid held during RUN/DONE must not disturb the result.
        if4.a = 4'd9; if4.b = 4'd3; if4.in_valid = 1'b1;
        @(posedge clk); #1;
        if4.a = 4'd1; if4.b = 4'd14;
        wait_valid4(nb);
        check("t4_first_diff", if4.diff, 6);
        check("t4_first_bout", if4.bout, 0);
        repeat (2) @(posedge clk);
        #1;
        check("t4_held_diff", if4.diff, 6);
        check("t4_no_accept_in_done", if4.in_ready, 0);
        if4.out_ready = 1'b1;
        @(posedge clk); #1;
        if4.out_ready = 1'b0;
        check("t4_idle_ready", if4.in_ready, 1);
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
        check("t4_second_busy", if4.busy, 1);
        wait_valid4(nb);
        check("t4_second_diff", if4.diff, 3);
        check("t4_second_bout", if4.bout, 1);
        if4.out_ready = 1'b1;
        @(posedge clk); #1;
        if4.out_ready = 1'b0;

        // Asynchronous reset two steps into RUN.
        if4.a = 4'd9; if4.b = 4'd3; if4.in_valid = 1'b1;
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", if4.out_valid, 0);
        check("t5_rst_diff", if4.diff, 0);
        check("t5_rst_in_ready", if4.in_ready, 1);
        check("t5_rst_busy", if4.busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op4(4'd8, 4'd1, 0, 7, 0, "t5_8m1");

        // WIDTH=8 sweep with random backpressure, edge operands first.
        sweep_on = 1'b1;
        for (int n = 0; n < 500; n++) begin
            int guard;
            guard = 0;
            while (!if8.in_ready && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 100) begin
                check("w8_in_ready_timeout", 0, 1);
                break;
            end
            case (n)
                0: begin if8.a = 8'd0;   if8.b = 8'd0;   end
                1: begin if8.a = 8'd255; if8.b = 8'd255; end
                2: begin if8.a = 8'd0;   if8.b = 8'd255; end
                3: begin if8.a = 8'd255; if8.b = 8'd0;   end
                default: begin if8.a = 8'($urandom); if8.b = 8'($urandom); end
            endcase
            if8.in_valid = 1'b1;
            @(posedge clk); #1;
            if8.in_valid = 1'b0;
        end
        begin
            int guard;
            guard = 0;
            while (q8.size() > 0 && guard < 200) begin
                @(posedge clk); #1;
                guard++;
            end
            check("w8_drain", q8.size(), 0);
        end
        sweep_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
